// File: rtl/vga_pkg.sv
// VGA receive monitor shared types and 640x480 timing.
// Imported by the monitor, its interface users and sub-blocks.
package vga_pkg;

  localparam int VGA_H_ACTIVE    = 640;
  localparam int VGA_H_FP        = 16;
  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_BP        = 48;
  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_V_ACTIVE    = 480;
  localparam int VGA_V_FP        = 10;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_BP        = 33;
  localparam int VGA_V_TOTAL     = 525;
  localparam int VGA_LOCK_FRAMES = 2;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic logic [23:0] sig_step(
    input logic [23:0] s,
    input rgb_t        p
  );
    return {s[22:0], s[23]} ^ p;
  endfunction

endpackage

// File: rtl/vga_rx_monitor_if.sv
// VGA pixel bus as seen by the receive monitor.
// master drives the bus, slave samples it.
interface vga_rx_monitor_if;

  logic       pix_ce;
  logic       hsync;
  logic       vsync;
  logic       blank;
  logic [7:0] R;
  logic [7:0] G;
  logic [7:0] B;

  modport master (
    output pix_ce, hsync, vsync, blank,
    output R, G, B
  );

  modport slave (
    input pix_ce, hsync, vsync, blank,
    input R, G, B
  );

endinterface

// File: rtl/vga_sync_edge.sv
// Falling-edge detector for an active-low sync line.
// Only pixel strobes update the history.
module vga_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic din,
  output logic fall
);

  logic q;

  // keep the level seen at the previous strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= 1'b0;
    else if (ce) q <= din;
  end

  assign fall = ce & q & ~din;

endmodule

// File: rtl/vga_rx_monitor.sv
// VGA receive monitor: timing lock, coordinates
// and a per-frame rotate-xor pixel signature.
module vga_rx_monitor
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic                    clk,
  input  logic                    reset,
  vga_rx_monitor_if.slave         vga,
  output logic [9:0]              x,
  output logic [9:0]              y,
  output logic                    pix_valid,
  output logic                    locked,
  output logic [23:0]             frame_sig,
  output logic                    frame_done,
  output logic                    sync_err,
  output logic [11:0]             h_meas,
  output logic [10:0]             v_meas
);

  logic        ce;
  logic        hfall;
  logic        vfall;
  rgb_t        px;
  state_t      state;
  logic [11:0] hcnt;
  logic [10:0] vcnt;
  logic [11:0] hvis;
  logic [9:0]  ycnt;
  logic        line_seen;
  logic [7:0]  good;
  logic [23:0] sig;

  logic [11:0] hlen;
  logic [10:0] vnext;
  logic [11:0] hbase;
  logic [9:0]  ybase;
  logic        chk;
  logic        vis;
  logic        tfail;
  logic        ovf;

  assign ce = vga.pix_ce;
  assign px = {vga.R, vga.G, vga.B};

  vga_sync_edge u_hedge (
    .clk  (clk),
    .reset(reset),
    .ce   (ce),
    .din  (vga.hsync),
    .fall (hfall)
  );

  vga_sync_edge u_vedge (
    .clk  (clk),
    .reset(reset),
    .ce   (ce),
    .din  (vga.vsync),
    .fall (vfall)
  );

  assign hlen  = (hcnt == 12'hfff) ? hcnt : hcnt + 12'd1;
  assign vnext = !hfall ? vcnt :
                 (vcnt == 11'h7ff) ? vcnt : vcnt + 11'd1;
  assign chk   = state != SEARCH;
  assign vis   = ce & vga.blank;
  assign hbase = hfall ? 12'd0 : hvis;
  assign tfail = chk & ((hfall & (hlen != 12'(H_TOTAL))) |
                        (vfall & (vnext != 11'(V_TOTAL))));
  assign ovf   = chk & vis & (hbase >= 12'(H_ACTIVE));

  // row of the current line: bumps once per visible line
  always_comb begin
    ybase = ycnt;
    if (hfall && line_seen && ycnt < 10'(V_ACTIVE - 1))
      ybase = ycnt + 10'd1;
    if (vfall) ybase = '0;
  end

  // line/frame length counters and measurements
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcnt   <= '0;
      vcnt   <= '0;
      h_meas <= '0;
      v_meas <= '0;
    end else if (ce) begin
      if (hfall) begin
        h_meas <= hlen;
        hcnt   <= '0;
      end else if (hcnt != 12'hfff) begin
        hcnt <= hcnt + 12'd1;
      end
      if (vfall) begin
        v_meas <= vnext;
        vcnt   <= '0;
      end else begin
        vcnt <= vnext;
      end
    end
  end

  // lock state machine and timing error pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= SEARCH;
      good     <= '0;
      sync_err <= 1'b0;
      locked   <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      locked   <= state == LOCKED;
      if (ce) begin
        if (tfail) begin
          state    <= SEARCH;
          sync_err <= 1'b1;
        end else begin
          sync_err <= ovf;
          unique case (state)
            SEARCH: if (vfall) begin
              state <= MEASURE;
              good  <= '0;
            end
            MEASURE: if (vfall) begin
              good <= good + 8'd1;
              if (good + 8'd1 == 8'(LOCK_FRAMES))
                state <= LOCKED;
            end
            LOCKED: ;
            default: state <= SEARCH;
          endcase
        end
      end
    end
  end

  // visible-pixel coordinates
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x         <= '0;
      y         <= '0;
      hvis      <= '0;
      ycnt      <= '0;
      line_seen <= 1'b0;
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= vis & locked;
      if (ce) begin
        ycnt <= ybase;
        if (hfall) begin
          x    <= '0;
          hvis <= '0;
        end
        if (vfall) y <= '0;
        if (hfall | vfall) line_seen <= 1'b0;
        if (vis) begin
          x <= (hbase >= 12'(H_ACTIVE - 1)) ?
               10'(H_ACTIVE - 1) : hbase[9:0];
          hvis <= (hbase == 12'hfff) ?
                  hbase : hbase + 12'd1;
          y         <= ybase;
          line_seen <= 1'b1;
        end
      end
    end
  end

  // frame signature, published on each good locked frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig        <= '0;
      frame_sig  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!locked) begin
        sig <= '0;
      end else if (ce) begin
        if (vfall) begin
          sig <= '0;
          if (!tfail) begin
            frame_sig  <= sig;
            frame_done <= 1'b1;
          end
        end else if (vis) begin
          sig <= sig_step(sig, px);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Randomized scoreboard bench for vga_rx_monitor.
// Uses a shrunken raster to keep runs short.
module tb_vga_rx_monitor;

  localparam int HA  = 8;
  localparam int HT  = 16;
  localparam int VA  = 6;
  localparam int VT  = 10;
  localparam int HS  = 2;
  localparam int HBP = 3;
  localparam int VS  = 2;
  localparam int VBP = 1;
  localparam int LF  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        pix_valid;
  logic        locked;
  logic [23:0] frame_sig;
  logic        frame_done;
  logic        sync_err;
  logic [11:0] h_meas;
  logic [10:0] v_meas;

  vga_rx_monitor_if vif ();

  vga_rx_monitor #(
    .H_ACTIVE   (HA),
    .H_TOTAL    (HT),
    .V_ACTIVE   (VA),
    .V_TOTAL    (VT),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .vga       (vif),
    .x         (x),
    .y         (y),
    .pix_valid (pix_valid),
    .locked    (locked),
    .frame_sig (frame_sig),
    .frame_done(frame_done),
    .sync_err  (sync_err),
    .h_meas    (h_meas),
    .v_meas    (v_meas)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int          mphase;
  int          mgood;
  logic [23:0] msig;
  logic [23:0] mfsig;
  int          last_len;
  int          last_lines;
  int          mx;
  int          my;

  logic [19:0] pixq[$];
  logic [23:0] sigq[$];
  int          errq[$];
  bit          lockq[$];

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] mix(input logic [23:0] s,
                                      input logic [23:0] c);
    logic [47:0] d;
    d = {s, s} << 1;
    return d[47:24] ^ c;
  endfunction

  task automatic drive(input logic hs, input logic vs,
                       input logic bl, input logic [23:0] c);
    int gap;
    gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    vif.hsync  = hs;
    vif.vsync  = vs;
    vif.blank  = bl;
    {vif.R, vif.G, vif.B} = c;
    vif.pix_ce = 1'b1;
    @(posedge clk);
    #1;
    vif.pix_ce = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 24'h0);
  endtask

  task automatic model_edge(input bit vf);
    bit err;
    err = 0;
    if (mphase != 0 && last_len != HT) err = 1;
    if (vf && mphase != 0 && last_lines != VT) err = 1;
    if (err) begin
      errq.push_back(1);
      if (mphase == 2) lockq.push_back(1'b0);
      mphase = 0;
      msig = 0;
    end else if (vf) begin
      if (mphase == 2) begin
        sigq.push_back(msig);
        mfsig = msig;
        msig = 0;
      end else if (mphase == 0) begin
        mphase = 1;
        mgood = 0;
      end else begin
        mgood++;
        if (mgood == LF) begin
          mphase = 2;
          msig = 0;
          lockq.push_back(1'b1);
        end
      end
    end
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_a"}, 64'({x, y, pix_valid, locked, frame_done, sync_err}), 64'd0);
    check({nm, "_b"}, 64'({frame_sig, h_meas, v_meas}), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    if (mphase == 2) lockq.push_back(1'b0);
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    mphase = 0;
    msig = 0;
    mfsig = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic stall_check();
    repeat (1000) @(posedge clk);
    #1;
    check("stall_x", 64'(x), 64'(mx));
    check("stall_y", 64'(y), 64'(my));
    check("stall_sig", 64'(frame_sig), 64'(mfsig));
  endtask

  task automatic run_frame(input int nl, input int short_ln,
                           input bit stall, input bit rmid,
                           input bit cconst);
    int len;
    logic hs, vs, bl;
    logic [23:0] c;
    for (int ln = 0; ln < nl; ln++) begin
      len = (ln == short_ln) ? HT - 1 : HT;
      for (int s = 0; s < len; s++) begin
        hs = s >= HS;
        vs = ln >= VS;
        bl = ln >= VS + VBP && ln < VS + VBP + VA &&
             s >= HS + HBP && s < HS + HBP + HA;
        c = cconst ? 24'h123456 : 24'($urandom);
        if (rmid && ln == 5 && s == 7) begin
          do_reset();
          return;
        end
        if (stall && ln == 4 && s == 9) stall_check();
        if (s == 0) model_edge(ln == 0);
        if (bl && mphase == 2) begin
          mx = s - HS - HBP;
          my = ln - VS - VBP;
          pixq.push_back({10'(mx), 10'(my)});
          msig = mix(msig, c);
        end
        drive(hs, vs, bl, c);
      end
      last_len = len;
    end
    last_lines = nl;
  endtask

  // scoreboard monitor: pops an expectation per DUT event
  initial begin
    bit plock;
    logic [19:0] ep;
    logic [23:0] es;
    plock = 1'b0;
    forever begin
      @(negedge clk);
      if (sync_err) begin
        total++;
        if (errq.size() == 0) begin
          bad++;
          $display("FAIL sync_err: got pulse want none");
        end else begin
          void'(errq.pop_front());
        end
      end
      if (frame_done) begin
        if (sigq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL frame_done: got pulse sig %0h want none", frame_sig);
        end else begin
          es = sigq.pop_front();
          check("frame_sig", 64'(frame_sig), 64'(es));
        end
      end
      if (pix_valid) begin
        if (pixq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pix_valid: got x=%0d y=%0d want none", x, y);
        end else begin
          ep = pixq.pop_front();
          check("pix_xy", 64'({x, y}), 64'(ep));
        end
      end
      if (locked !== plock) begin
        if (lockq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL locked: got %0b want %0b", locked, plock);
        end else begin
          check("locked_edge", 64'(locked), 64'(lockq.pop_front()));
        end
        plock = locked;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    mphase = 0;
    mgood = 0;
    msig = 0;
    mfsig = 0;
    last_len = HT;
    last_lines = VT;
    mx = 0;
    my = 0;
    vif.pix_ce = 1'b0;
    vif.hsync = 1'b1;
    vif.vsync = 1'b1;
    vif.blank = 1'b0;
    vif.R = 8'h0;
    vif.G = 8'h0;
    vif.B = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst_init");
    rst_n = 1'b1;
    idle(6);

    run_frame(VT, -1, 0, 0, 0);
    check("lock_f1", 64'(locked), 64'd0);
    run_frame(VT, -1, 0, 0, 0);
    check("lock_f2", 64'(locked), 64'd0);
    check("h_meas", 64'(h_meas), 64'(HT));
    check("v_meas", 64'(v_meas), 64'(VT));
    run_frame(VT, -1, 0, 0, 0);
    check("lock_f3", 64'(locked), 64'd1);
    run_frame(VT, -1, 0, 0, 1);
    run_frame(VT, -1, 1, 0, 0);
    check("const_sig", 64'(frame_sig), 64'(mfsig));

    run_frame(VT, 5, 0, 0, 0);
    check("short_unlock", 64'(locked), 64'd0);
    run_frame(VT, -1, 0, 0, 0);
    run_frame(VT, -1, 0, 0, 0);
    check("relock_pre", 64'(locked), 64'd0);
    run_frame(VT, -1, 0, 0, 0);
    check("relock", 64'(locked), 64'd1);

    run_frame(VT - 1, -1, 0, 0, 0);
    run_frame(VT, -1, 0, 0, 0);
    check("short_frame_sig", 64'(frame_sig), 64'(mfsig));
    check("short_v_meas", 64'(v_meas), 64'(VT - 1));
    check("short_frame_lock", 64'(locked), 64'd0);
    run_frame(VT, -1, 0, 0, 0);
    run_frame(VT, -1, 0, 0, 0);
    run_frame(VT, -1, 0, 0, 0);
    run_frame(VT, -1, 0, 1, 0);

    idle(6);
    for (int f = 0; f < 5; f++) run_frame(VT, -1, 0, 0, 0);
    check("final_lock", 64'(locked), 64'd1);
    check("final_sig", 64'(frame_sig), 64'(mfsig));

    repeat (4) @(posedge clk);
    #1;
    check("pixq_left", 64'(pixq.size()), 64'd0);
    check("sigq_left", 64'(sigq.size()), 64'd0);
    check("errq_left", 64'(errq.size()), 64'd0);
    check("lockq_left", 64'(lockq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
